// File: rtl/trap_pkg.sv
// Shared constants for the trap pending controller: sizes, FSM encoding, trap indices.
// Bit 0 of the pending vector is the highest-priority trap source.
package trap_pkg;

  localparam int N_TRAPS = 6;
  localparam int TT_W    = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_REQ   = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;
  localparam state_t ST_ERROR = 2'd3;

  localparam logic [TT_W-1:0] TRAP_0 = 3'd0;
  localparam logic [TT_W-1:0] TRAP_1 = 3'd1;
  localparam logic [TT_W-1:0] TRAP_2 = 3'd2;
  localparam logic [TT_W-1:0] TRAP_3 = 3'd3;
  localparam logic [TT_W-1:0] TRAP_4 = 3'd4;
  localparam logic [TT_W-1:0] TRAP_5 = 3'd5;

endpackage

// File: rtl/tt_decode.sv
// Combinational decode of an acknowledged tt code to a one-hot pending-bit mask.
// Codes at or above N_TRAPS decode to all-zero and report out of range.
module tt_decode
  import trap_pkg::*;
(
  input  logic [TT_W-1:0]    i_tt,
  output logic [N_TRAPS-1:0] o_onehot,
  output logic               o_in_range
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N_TRAPS; i++) begin
      if (i_tt == TT_W'(i)) o_onehot[i] = 1'b1;
    end
  end

  assign o_in_range = (i_tt < TT_W'(N_TRAPS));

endmodule

// File: rtl/trap_pending_ctl.sv
// Sticky trap pending vector with service-request FSM and ET=0 error trap.
// Pending bits visible one cycle after trap_set; request one cycle after that.
module trap_pending_ctl
  import trap_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_TRAPS-1:0] trap_set,
  input  logic               et,
  input  logic               tt_ack,
  input  logic [TT_W-1:0]    tt_in,
  output logic [N_TRAPS-1:0] tq_out,
  output logic               tt_strobe,
  output logic               trap_req,
  output logic               ack_err,
  output logic               error_mode
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_TRAPS-1:0] r_tq;
  logic               r_strobe;
  logic               r_ack_err;

  logic [N_TRAPS-1:0] w_onehot;
  logic [N_TRAPS-1:0] w_clr_mask;
  logic               w_in_range;
  logic               w_ack_hit;
  logic               w_ack_take;
  logic               w_ack_bad;
  logic               w_err_trip;

  tt_decode u_tt_decode (
    .i_tt       (tt_in),
    .o_onehot   (w_onehot),
    .o_in_range (w_in_range)
  );

  assign w_err_trip = (r_state != ST_ERROR) && (|trap_set) && !et;
  assign w_ack_hit  = w_in_range && (|(w_onehot & r_tq));
  // An ack in the error cycle is dropped entirely: no clear and no ack_err.
  assign w_ack_take = (r_state == ST_REQ) && tt_ack && !w_err_trip;
  assign w_clr_mask = (w_ack_take && w_ack_hit) ? w_onehot : '0;
  assign w_ack_bad  = w_ack_take && !w_ack_hit;

  always_comb begin
    w_state_nxt = r_state;
    if (w_err_trip) begin
      w_state_nxt = ST_ERROR;
    end else begin
      case (r_state)
        ST_IDLE: if (et && (|r_tq)) w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (tt_ack)   w_state_nxt = ST_HOLD;
          else if (!et) w_state_nxt = ST_IDLE;
        end
        ST_HOLD:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tq      <= '0;
      r_strobe  <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Set wins over a same-cycle clear of the same bit.
      r_tq      <= (r_tq & ~w_clr_mask) | trap_set;
      r_strobe  <= (r_state == ST_IDLE) && (w_state_nxt == ST_REQ);
      r_ack_err <= w_ack_bad;
    end
  end

  assign tq_out     = r_tq;
  assign tt_strobe  = r_strobe;
  assign trap_req   = (r_state == ST_REQ);
  assign ack_err    = r_ack_err;
  assign error_mode = (r_state == ST_ERROR);

endmodule
